// File: rtl/icache_if.sv
// Fetch/refill bus for the direct-mapped instruction cache.
// The slave side is the cache; the master side is the fetch unit plus the memory controller.
interface icache_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              cache_rd_en;
  logic [ADDR_W-1:0] cache_rd_addr;
  logic              cache_hit;
  logic [WORD_W-1:0] cache_hit_inst;
  logic              cache_flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [WORD_W-1:0] mem_data;

  modport slave (
    input  cache_rd_en, cache_rd_addr, cache_flush, mem_done, mem_data,
    output cache_hit, cache_hit_inst, mem_req, mem_addr
  );

  modport master (
    output cache_rd_en, cache_rd_addr, cache_flush, mem_done, mem_data,
    input  cache_hit, cache_hit_inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per line.
// Lookups are combinational; misses run a single-word refill over a req/done handshake.
module icache #(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  icache_if.slave   bus
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       miss_addr_q, miss_addr_d;
  logic                    drop_q, drop_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [TAG_W-1:0]        tag_d  [LINES];
  logic [WORD_W-1:0]       data_q [LINES];
  logic [WORD_W-1:0]       data_d [LINES];

  logic [INDEX_BITS-1:0]   rd_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic [INDEX_BITS-1:0]   miss_idx;
  logic [TAG_W-1:0]        miss_tag;
  logic                    lookup_hit;
  logic                    start_miss;
  logic                    fill_en;
  logic                    unused_addr_lsbs;

  assign rd_idx   = bus.cache_rd_addr[INDEX_BITS+1:2];
  assign rd_tag   = bus.cache_rd_addr[ADDR_W-1:INDEX_BITS+2];
  assign miss_idx = miss_addr_q[INDEX_BITS+1:2];
  assign miss_tag = miss_addr_q[ADDR_W-1:INDEX_BITS+2];

  // Fetch addresses are word aligned; the byte offset carries no information.
  assign unused_addr_lsbs = ^bus.cache_rd_addr[1:0];

  // Read path: no fill-to-hit bypass, so a line only hits once its write has landed.
  assign lookup_hit         = bus.cache_rd_en & valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag) & ~rst;
  assign bus.cache_hit      = lookup_hit;
  assign bus.cache_hit_inst = lookup_hit ? data_q[rd_idx] : '0;

  assign start_miss = rdy & (state_q == S_IDLE) & bus.cache_rd_en & ~lookup_hit & ~bus.cache_flush;

  // A flush in the same cycle as mem_done, or any earlier flush during the refill, suppresses the write.
  assign fill_en = rdy & (state_q == S_WAIT) & bus.mem_done & ~drop_q & ~bus.cache_flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value; combinational blocks use blocking (=) to build _d values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_miss)              state_d = S_WAIT;
      S_WAIT: if (rdy && bus.mem_done)     state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. mem_addr comes straight from the latched miss address, so it
  // is stable for the whole refill regardless of rollback on cache_rd_addr.
  always_comb begin
    bus.mem_req  = (state_q == S_WAIT);
    bus.mem_addr = miss_addr_q;
  end

  // ---------------------------------------------------------------------------
  // Miss bookkeeping and line state
  // ---------------------------------------------------------------------------
  always_comb begin
    miss_addr_d = miss_addr_q;
    drop_d      = drop_q;
    valid_d     = valid_q;

    if (start_miss) begin
      miss_addr_d = {bus.cache_rd_addr[ADDR_W-1:2], 2'b00};
    end

    if (rdy && (state_q == S_WAIT)) begin
      if (bus.mem_done) begin
        drop_d = 1'b0;
      end else if (bus.cache_flush) begin
        drop_d = 1'b1;
      end
    end

    if (fill_en) begin
      valid_d[miss_idx] = 1'b1;
    end
    if (rdy && bus.cache_flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    tag_d  = tag_q;
    data_d = data_q;
    if (fill_en) begin
      tag_d[miss_idx]  = miss_tag;
      data_d[miss_idx] = bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_addr_q <= '0;
      drop_q      <= 1'b0;
      valid_q     <= '0;
    end else begin
      miss_addr_q <= miss_addr_d;
      drop_q      <= drop_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents are ever observed.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a line-level model checked every cycle plus literal
// expectations for the cold miss, conflict, rollback, flush, stall, wrap and reset cases.
module tb_icache;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;

  logic clk;
  logic rst;
  logic rdy;

  icache_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  icache #(.INDEX_BITS(6), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: each line remembers the full word address it holds.
  // ---------------------------------------------------------------------------
  bit              m_valid [64];
  bit [29:0]       m_word  [64];
  bit [31:0]       m_data  [64];
  bit              m_pending;
  bit              m_drop;
  bit [31:0]       m_addr;
  bit              m_h;

  function automatic bit model_hit();
    int i;
    i = int'(bus.cache_rd_addr[7:2]);
    return bus.cache_rd_en && !rst && m_valid[i] && (m_word[i] == bus.cache_rd_addr[31:2]);
  endfunction

  always @(posedge clk) begin
    m_h = model_hit();
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_pending = 1'b0;
      m_drop    = 1'b0;
      m_addr    = '0;
    end else if (rdy) begin
      if (m_pending) begin
        if (bus.mem_done) begin
          if (!m_drop && !bus.cache_flush) begin
            m_valid[m_addr[7:2]] = 1'b1;
            m_word[m_addr[7:2]]  = m_addr[31:2];
            m_data[m_addr[7:2]]  = bus.mem_data;
          end
          m_pending = 1'b0;
          m_drop    = 1'b0;
        end else if (bus.cache_flush) begin
          m_drop = 1'b1;
        end
      end else if (bus.cache_rd_en && !m_h && !bus.cache_flush) begin
        m_pending = 1'b1;
        m_addr    = {bus.cache_rd_addr[31:2], 2'b00};
      end
      if (bus.cache_flush) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
      end
    end
  end

  bit compare_on = 1'b0;

  always @(negedge clk) begin
    if (compare_on) begin
      bit eh;
      eh = model_hit();
      check("cyc_hit", bus.cache_hit, eh);
      check("cyc_inst", bus.cache_hit_inst, eh ? m_data[bus.cache_rd_addr[7:2]] : 32'h0);
      check("cyc_mem_req", bus.mem_req, m_pending);
      if (m_pending) check("cyc_mem_addr", bus.mem_addr, m_addr);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !bus.mem_req; i++) tick();
    check("mem_req_seen", bus.mem_req, 1'b1);
  endtask

  task automatic respond(input logic [31:0] d);
    wait_req();
    bus.mem_done = 1'b1;
    bus.mem_data = d;
    tick();
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = a;
    tick();
    respond(d);
    check("fill_hit", bus.cache_hit, 1'b1);
    check("fill_inst", bus.cache_hit_inst, d);
  endtask

  task automatic probe_miss(input string name, input logic [31:0] a);
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = a;
    #1;
    check(name, bus.cache_hit, 1'b0);
    bus.cache_rd_en = 1'b0;
    tick();
  endtask

  logic [31:0] flushed_addrs [6] = '{32'h0, 32'h4, 32'h104, 32'h40, 32'h80, 32'h200};

  initial begin
    rst               = 1'b1;
    rdy               = 1'b1;
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = 32'h0;
    bus.cache_flush   = 1'b0;
    bus.mem_done      = 1'b0;
    bus.mem_data      = '0;
    compare_on        = 1'b1;

    tick();
    tick();
    check("rst_hit", bus.cache_hit, 1'b0);
    check("rst_inst", bus.cache_hit_inst, 32'h0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);

    // Cold miss on address 0
    rst = 1'b0;
    #1;
    check("cold_hit0", bus.cache_hit, 1'b0);
    tick();
    check("cold_req", bus.mem_req, 1'b1);
    check("cold_addr", bus.mem_addr, 32'h0);
    tick();
    check("cold_no_bypass", bus.cache_hit, 1'b0);
    respond(32'h0000_0513);
    check("cold_hit1", bus.cache_hit, 1'b1);
    check("cold_inst", bus.cache_hit_inst, 32'h0000_0513);
    check("cold_req_off", bus.mem_req, 1'b0);

    // Conflict on idx 1
    fill(32'h0000_0004, 32'h0000_0293);
    fill(32'h0000_0104, 32'h0000_0313);
    bus.cache_rd_addr = 32'h0000_0004;
    #1;
    check("conflict_evicted", bus.cache_hit, 1'b0);
    tick();
    respond(32'h0000_0293);
    check("conflict_refill", bus.cache_hit_inst, 32'h0000_0293);

    // Rollback mid-miss
    bus.cache_rd_addr = 32'h0000_0040;
    tick();
    bus.cache_rd_addr = 32'h0000_0080;
    tick();
    check("rollback_addr_held", bus.mem_addr, 32'h0000_0040);
    respond(32'hC0DE_0040);
    check("rollback_new_miss", bus.cache_hit, 1'b0);
    tick();
    check("rollback_req2", bus.mem_req, 1'b1);
    check("rollback_addr2", bus.mem_addr, 32'h0000_0080);
    respond(32'hC0DE_0080);
    check("rollback_hit80", bus.cache_hit_inst, 32'hC0DE_0080);
    bus.cache_rd_addr = 32'h0000_0040;
    #1;
    check("rollback_hit40", bus.cache_hit, 1'b1);
    check("rollback_inst40", bus.cache_hit_inst, 32'hC0DE_0040);

    // Flush while a refill is in flight
    bus.cache_rd_addr = 32'h0000_0200;
    tick();
    bus.cache_flush = 1'b1;
    bus.cache_rd_en = 1'b0;
    tick();
    bus.cache_flush = 1'b0;
    check("flush_wait_req", bus.mem_req, 1'b1);
    respond(32'hDEAD_0200);
    check("flush_wait_idle", bus.mem_req, 1'b0);
    foreach (flushed_addrs[i]) probe_miss("flush_wait_miss", flushed_addrs[i]);

    // Flush in the same cycle as mem_done
    fill(32'h0000_0300, 32'h0000_0300);
    bus.cache_rd_addr = 32'h0000_0000;
    tick();
    check("race_req", bus.mem_req, 1'b1);
    bus.cache_rd_en  = 1'b0;
    bus.mem_done     = 1'b1;
    bus.mem_data     = 32'hBAD0_0000;
    bus.cache_flush  = 1'b1;
    tick();
    bus.mem_done    = 1'b0;
    bus.cache_flush = 1'b0;
    check("race_idle", bus.mem_req, 1'b0);
    probe_miss("race_miss300", 32'h0000_0300);
    probe_miss("race_miss0", 32'h0000_0000);

    // rdy stall during refill, including a frozen rollback
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = 32'h0000_0500;
    tick();
    rdy = 1'b0;
    bus.cache_rd_addr = 32'h0000_0600;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", bus.mem_req, 1'b1);
      check("stall_addr", bus.mem_addr, 32'h0000_0500);
    end
    rdy = 1'b1;
    bus.cache_rd_en = 1'b0;
    respond(32'h0050_0513);
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = 32'h0000_0500;
    #1;
    check("stall_fill_hit", bus.cache_hit, 1'b1);
    check("stall_fill_inst", bus.cache_hit_inst, 32'h0050_0513);

    // Address wrap: top word maps to idx 63
    fill(32'hFFFF_FFFC, 32'h1234_5678);
    probe_miss("wrap_alias_fc", 32'h0000_00FC);

    // Reset during a refill, then a stray mem_done
    bus.cache_rd_en   = 1'b1;
    bus.cache_rd_addr = 32'h0000_0700;
    tick();
    check("rstw_req", bus.mem_req, 1'b1);
    bus.cache_rd_en = 1'b0;
    rst = 1'b1;
    tick();
    check("rstw_req_off", bus.mem_req, 1'b0);
    check("rstw_addr0", bus.mem_addr, 32'h0);
    rst = 1'b0;
    tick();
    bus.mem_done = 1'b1;
    bus.mem_data = 32'hBAD0_0700;
    tick();
    bus.mem_done = 1'b0;
    check("rstw_stray_req", bus.mem_req, 1'b0);
    probe_miss("rstw_miss700", 32'h0000_0700);
    probe_miss("rstw_miss_wrap", 32'hFFFF_FFFC);

    tick();
    compare_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
